// File: rtl/mux41_pkg.sv
// Shared types and the round-robin search for the 4-requester mux arbiter.
package mux41_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef struct packed {
      logic             found;
      logic [SEL_W-1:0] idx;
   } rrRes_t;

   // Searches ptr+1, ptr+2, ... with wrap; ptr itself is tried last unless excluded.
   function automatic rrRes_t rr_next(
      input logic [N_REQ-1:0] req,
      input logic [SEL_W-1:0] ptr,
      input logic             excludePtr
   );
      rrRes_t           res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ptr + SEL_W'(k);
         if (!res.found && req[idx] && !(k == N_REQ && excludePtr)) begin
            res.found = 1'b1;
            res.idx   = idx;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mux41_rr_arbiter_sel.sv
// 4:1 selector for 4-bit words, select taken as {iS1,iS0}.
module selector41
   import mux41_pkg::*;
(
   input  logic       iS1,
   input  logic       iS0,
   input  logic [3:0] iC0,
   input  logic [3:0] iC1,
   input  logic [3:0] iC2,
   input  logic [3:0] iC3,
   output logic [3:0] oZ
);

   always_comb begin
      unique case ({iS1, iS0})
         2'b00: oZ = iC0;
         2'b01: oZ = iC1;
         2'b10: oZ = iC2;
         2'b11: oZ = iC3;
      endcase
   end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter with bounded hold driving a shared 4:1 word selector.
module mux41_rr_arbiter
   import mux41_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic [N_REQ-1:0] iReq,
   input  logic [3:0]       iC0,
   input  logic [3:0]       iC1,
   input  logic [3:0]       iC2,
   input  logic [3:0]       iC3,
   output logic [N_REQ-1:0] oGnt,
   output logic             oS1,
   output logic             oS0,
   output logic [3:0]       oZ,
   output logic             oValid
);

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       selWord;
   rrRes_t           rrAny;
   rrRes_t           rrOther;

   selector41 uSel (
      .iS1 (oS1),
      .iS0 (oS0),
      .iC0 (iC0),
      .iC1 (iC1),
      .iC2 (iC2),
      .iC3 (iC3),
      .oZ  (selWord)
   );

   assign rrAny   = rr_next(iReq, ptr, 1'b0);
   assign rrOther = rr_next(iReq, ptr, 1'b1);

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state      <= IDLE;
         ptr        <= 2'd3;
         cnt        <= '0;
         oGnt       <= '0;
         {oS1, oS0} <= 2'b00;
         oZ         <= '0;
         oValid     <= 1'b0;
      end else begin
         // Data path follows the grant that was visible before this edge
         oValid <= (state == GRANT);
         oZ     <= (state == GRANT) ? selWord : 4'h0;
         unique case (state)
            IDLE: begin
               if (rrAny.found) begin
                  state      <= GRANT;
                  oGnt       <= N_REQ'(1) << rrAny.idx;
                  {oS1, oS0} <= rrAny.idx;
                  ptr        <= rrAny.idx;
                  cnt        <= CNT_W'(1);
               end
            end
            GRANT: begin
               if (rrOther.found && (!iReq[ptr] || cnt == HOLD_MAX)) begin
                  oGnt       <= N_REQ'(1) << rrOther.idx;
                  {oS1, oS0} <= rrOther.idx;
                  ptr        <= rrOther.idx;
                  cnt        <= CNT_W'(1);
               end else if (!iReq[ptr]) begin
                  state <= IDLE;
                  oGnt  <= '0;
                  cnt   <= '0;
               end else if (cnt != HOLD_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter with hand-computed expectations.
module tb_mux41_rr_arbiter;

   logic       iClk = 1'b0;
   logic       iRst_n;
   logic [3:0] iReq;
   logic [3:0] iC0, iC1, iC2, iC3;
   logic [3:0] oGnt;
   logic       oS1, oS0;
   logic [3:0] oZ;
   logic       oValid;

   int nPass   = 0;
   int nChecks = 0;

   mux41_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .iReq   (iReq),
      .iC0    (iC0),
      .iC1    (iC1),
      .iC2    (iC2),
      .iC3    (iC3),
      .oGnt   (oGnt),
      .oS1    (oS1),
      .oS0    (oS0),
      .oZ     (oZ),
      .oValid (oValid)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nChecks++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   function automatic logic [3:0] dataOf(input int idx);
      logic [3:0] words [4];
      words = '{4'h1, 4'h2, 4'h3, 4'h4};
      return words[idx];
   endfunction

   logic [3:0] expG;
   int         idx;
   int         prev;

   initial begin
      iRst_n = 1'b0;
      iReq   = 4'b0000;
      iC0 = 4'h1; iC1 = 4'h2; iC2 = 4'hA; iC3 = 4'h4;
      step(); step();
      check("rstGnt", 8'(oGnt), 8'h0);
      check("rstSel", 8'({oS1, oS0}), 8'h0);
      check("rstZ", 8'(oZ), 8'h0);
      check("rstValid", 8'(oValid), 8'h0);

      // single requester 2
      iRst_n = 1'b1;
      iReq   = 4'b0100;
      step();
      check("singleGnt", 8'(oGnt), 8'h4);
      check("singleSel", 8'({oS1, oS0}), 8'h2);
      check("singleValid0", 8'(oValid), 8'h0);
      step();
      check("singleZ", 8'(oZ), 8'hA);
      check("singleValid1", 8'(oValid), 8'h1);
      step();
      iReq = 4'b0000;
      step();
      check("dropGnt", 8'(oGnt), 8'h0);
      check("dropValidLag", 8'(oValid), 8'h1);
      step();
      check("dropValid", 8'(oValid), 8'h0);
      check("dropZ", 8'(oZ), 8'h0);
      check("dropSelHold", 8'({oS1, oS0}), 8'h2);

      // wrap: last grant 3, then 1 and 3 rise together
      iReq = 4'b1000;
      step();
      check("wrapSetup", 8'(oGnt), 8'h8);
      iReq = 4'b0000;
      step(); step();
      iReq = 4'b1010;
      step();
      check("wrapGnt", 8'(oGnt), 8'h2);
      check("wrapSel", 8'({oS1, oS0}), 8'h1);
      iReq = 4'b0000;
      step(); step();

      // hold limit with 0 and 1 contending (last grant 1 -> 0 wins first)
      iReq = 4'b0011;
      for (int i = 0; i < 24; i++) begin
         step();
         expG = ((i / 8) % 2 == 1) ? 4'b0010 : 4'b0001;
         check($sformatf("hold%0d", i), 8'(oGnt), 8'(expG));
      end
      iReq = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         step();
         if (i % 5 == 4) check($sformatf("alone%0d", i), 8'(oGnt), 8'h1);
      end
      iReq = 4'b0000;
      step(); step();

      // reset mid-grant
      iReq = 4'b0100;
      step();
      check("preRstGnt", 8'(oGnt), 8'h4);
      step();
      iRst_n = 1'b0;
      #1;
      check("asyncGnt", 8'(oGnt), 8'h0);
      check("asyncSel", 8'({oS1, oS0}), 8'h0);
      check("asyncZ", 8'(oZ), 8'h0);
      check("asyncValid", 8'(oValid), 8'h0);
      iReq   = 4'b0001;
      iRst_n = 1'b1;
      step();
      check("postRstGnt", 8'(oGnt), 8'h1);
      iReq = 4'b0000;
      iRst_n = 1'b0;
      step();

      // round robin with data tracking, all four contending from reset
      iC2    = 4'h3;
      iRst_n = 1'b1;
      iReq   = 4'b1111;
      prev   = 0;
      for (int r = 0; r < 5; r++) begin
         idx = r % 4;
         step();
         iReq = 4'b1111;
         check($sformatf("rrGntA%0d", r), 8'(oGnt), 8'(4'b0001 << idx));
         if (r > 0) begin
            check($sformatf("rrZPrev%0d", r), 8'(oZ), 8'(dataOf(prev)));
            check($sformatf("rrValidA%0d", r), 8'(oValid), 8'h1);
         end
         step();
         check($sformatf("rrGntB%0d", r), 8'(oGnt), 8'(4'b0001 << idx));
         check($sformatf("rrSel%0d", r), 8'({oS1, oS0}), 8'(idx));
         check($sformatf("rrZ%0d", r), 8'(oZ), 8'(dataOf(idx)));
         iReq = 4'b1111 & ~(4'b0001 << idx);
         prev = idx;
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 4-channel, 4-bit selector datapath.
- Four requesters each present a 4-bit word and a request line. The block grants one requester at a time and drives the 2-bit select (oS1,oS0) of the 4:1 mux. It also registers the muxed word onto a shared output bus with a valid flag.
- Bounded hold time guarantees fairness under continuous contention.

Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles for one requester while another is pending; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous active-low reset.
- iReq  input  4  request, bit n = requester n; level-sensitive.
- iC0, iC1, iC2, iC3  input  4 each  data word of requester 0..3.
- oGnt  output  4  one-hot grant, registered; all-zero when idle.
- oS1, oS0  output  1 each  mux select = index of current/last grantee, registered.
- oZ  output  4  registered muxed data.
- oValid  output  1  oZ holds granted data this cycle.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low on iRst_n. While iRst_n=0: oGnt=0000, {oS1,oS0}=00, oZ=0000, oValid=0, state=IDLE, hold counter=0, last-grant pointer=3 (next search starts at 0).
  - Release of reset is taken synchronously; the first grant can occur on the first rising edge after release.
- State IDLE:
  - If iReq==0000, stay in IDLE; outputs keep their reset values except that {oS1,oS0} holds its last value.
  - Otherwise, at the edge, grant the winner = first set bit of iReq searching (ptr+1) mod 4 upward with wrap. Set oGnt=onehot(winner), {oS1,oS0}=winner, ptr=winner, counter=1, and go to GRANT.
  - Latency is 1 cycle from request sampled to oGnt visible.
- State GRANT, evaluated each edge with cur=ptr:
  - iReq[cur]=0: the grantee releases. If another request is set, grant the next round-robin winner in the same edge (no idle bubble) with counter=1. Otherwise oGnt=0000 and go to IDLE.
  - iReq[cur]=1, counter==MAX_HOLD, and any other iReq bit set: forced switch to the next round-robin winner (cur is excluded from the search), counter=1.
  - iReq[cur]=1 otherwise: keep the grant. The counter increments and saturates at MAX_HOLD; when cur is the only requester it keeps the grant indefinitely.
- Data path:
  - At each edge, oValid <= (state==GRANT) and oZ <= selected word when state==GRANT, else 0000. Both are based on the pre-edge grant/select.
  - oZ/oValid therefore trail oGnt by one cycle.
  - A requester must hold its data stable while its oGnt bit is high.
- Simultaneous events:
  - When several bits rise together, round-robin order from ptr+1 decides; there is no fixed priority.
  - When the grantee drops its request in the same cycle a new requester rises, the new requester is eligible for the switch on that edge.
- Invariants:
  - oGnt is always one-hot or zero.
  - oGnt never names a requester whose iReq was 0 at the granting edge.
  - {oS1,oS0} equals the index of oGnt whenever oGnt is nonzero.
- Reset mid-grant: all outputs clear immediately (asynchronously); no residual grant, valid or pointer state survives.

Decomposition:
- Shared package (mux41_pkg):
  - state encoding, IDLE=1'b0 / GRANT=1'b1.
  - N_REQ=4 and SEL_W=2 constants.
  - a function rr_next(req[3:0], ptr[1:0], exclude_ptr) returning the winner index and a found flag.
- Sub-module: the existing 4:1 4-bit selector (selector41), instantiated with iS1/iS0 driven from the registered select; its output feeds the oZ register.
- Arbitration FSM, counter and pointer live in the top module.

Test Plan:
- Reset: assert iRst_n=0 mid-GRANT with iReq=0100 -> oGnt=0000, {oS1,oS0}=00, oZ=0000, oValid=0 immediately. After release with iReq=0001 -> oGnt=0001 one edge later.
- Single requester: iReq=0100, iC2=4'hA held 3 cycles -> oGnt=0100, {oS1,oS0}=10, then oZ=4'hA with oValid=1 one cycle later. Drop iReq -> oGnt=0000 next edge, oValid=0 the edge after.
- Round robin: iReq=1111 constant from reset, each requester drops after 2 granted cycles and re-requests -> grant order 0,1,2,3,0 with no idle cycles between grants.
- Hold limit: iReq=0011 constant, MAX_HOLD=8 -> requester 0 granted exactly 8 cycles, then requester 1 for 8, alternating. Requester 0 alone with iReq=0001 keeps the grant for 20+ cycles.
- Wrap and simultaneity: ptr=3 (last grant 3), then iReq=1010 rises together -> requester 1 wins, never 3.
- Data tracking: iC0..iC3 = 1,2,3,4 with grants cycling -> oZ sequence 1,2,3,4 each one cycle after the matching oGnt, oValid high throughout.
